// File: rtl/truth_sweep_pkg.sv
// truth_sweep_pkg
// Shared definitions for the truth_sweep block. It holds the encodings of the
// four function selects and the sweep FSM state type. Both the top and the
// NOR network import this package.
package truth_sweep_pkg;

  // Function select encodings carried on the op port.
  localparam logic [1:0] OP_NAND_A = 2'd0;  // ~a & b
  localparam logic [1:0] OP_NAND_B = 2'd1;  // a & ~b
  localparam logic [1:0] OP_NOR    = 2'd2;  // ~(a | b)
  localparam logic [1:0] OP_NAND   = 2'd3;  // ~(a & b)

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/truth_sweep_nor_net.sv
// nor_net
// Purpose: builds all four truth_sweep functions from two-input NOR gates
// only. A final selector picks the one that op asks for.
// Ports:
//   a, b (in, W)  operands
//   op   (in, 2)  function select (see truth_sweep_pkg)
//   y    (out, W) selected NOR-built result
module nor_net
  import truth_sweep_pkg::*;
#(
  parameter int W = 2
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [1:0]   op,
  output logic [W-1:0] y
);

  logic [W-1:0] not_a;
  logic [W-1:0] not_b;
  logic [W-1:0] y_nand_a;
  logic [W-1:0] y_nand_b;
  logic [W-1:0] y_nor;
  logic [W-1:0] a_and_b;
  logic [W-1:0] y_nand;

  // An inverter is a NOR with both inputs tied together.
  assign not_a    = ~(a | a);
  assign not_b    = ~(b | b);
  assign y_nand_a = ~(a | not_b);        // ~a & b
  assign y_nand_b = ~(not_a | b);        // a & ~b
  assign y_nor    = ~(a | b);
  assign a_and_b  = ~(not_a | not_b);    // a & b
  assign y_nand   = ~(a_and_b | a_and_b);

  always_comb begin
    y = y_nor;
    case (op)
      OP_NAND_A: y = y_nand_a;
      OP_NAND_B: y = y_nand_b;
      OP_NOR:    y = y_nor;
      OP_NAND:   y = y_nand;
      default:   y = y_nor;
    endcase
  end

endmodule

// File: rtl/truth_sweep.sv
// truth_sweep
// Purpose: exhaustively sweeps every {a, b} operand pair for one function
// select. Each vector goes through a NOR-only structural network and through a
// behavioural expression. The block counts the vectors where the two disagree
// and reports pass when none did.
// Ports:
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   start          sweep request, only honoured in IDLE
//   op (2)         function select, latched at start
//   fault_inj      only with TRUTH_SWEEP_FAULT_INJ_EN: flips result bit 0 in RUN
//   busy           high in RUN and DRAIN
//   done           one-cycle pulse when the sweep result is final
//   vec_a, vec_b   current stimulus operands (vec_a = upper counter bits)
//   res_s          registered structural result of the previous vector
//   mismatch_cnt   mismatching vectors in the last or current sweep
//   pass           last completed sweep had no mismatches
// Configuration: define TRUTH_SWEEP_FAULT_INJ_EN to add the fault_inj port.
module truth_sweep
  import truth_sweep_pkg::*;
#(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   op,
`ifdef TRUTH_SWEEP_FAULT_INJ_EN
  input  logic         fault_inj,
`endif
  output logic         busy,
  output logic         done,
  output logic [W-1:0] vec_a,
  output logic [W-1:0] vec_b,
  output logic [W-1:0] res_s,
  output logic [2*W:0] mismatch_cnt,
  output logic         pass
);

  localparam int N  = 2**(2*W);
  localparam int CW = 2*W+1;

  localparam logic [2*W-1:0] VEC_ONE  = (2*W)'(1);
  localparam logic [2*W-1:0] VEC_LAST = (2*W)'(N-1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  state_t         state;
  state_t         next_state;
  logic [2*W-1:0] vec_cnt;
  logic [1:0]     op_q;
  logic [W-1:0]   res_nor;
  logic [W-1:0]   res_struct;
  logic [W-1:0]   res_beh;
  logic           cmp_flag;
  logic           cmp_valid;

  assign vec_a = vec_cnt[2*W-1:W];
  assign vec_b = vec_cnt[W-1:0];
  assign busy  = (state == RUN) || (state == DRAIN);

  nor_net #(.W(W)) u_nor_net (
    .a  (vec_a),
    .b  (vec_b),
    .op (op_q),
    .y  (res_nor)
  );

`ifdef TRUTH_SWEEP_FAULT_INJ_EN
  always_comb begin
    res_struct    = res_nor;
    res_struct[0] = res_nor[0] ^ (fault_inj && (state == RUN));
  end
`else
  assign res_struct = res_nor;
`endif

  // Golden reference written straight from the function definitions.
  always_comb begin
    res_beh = ~(vec_a | vec_b);
    case (op_q)
      OP_NAND_A: res_beh = ~vec_a & vec_b;
      OP_NAND_B: res_beh = vec_a & ~vec_b;
      OP_NOR:    res_beh = ~(vec_a | vec_b);
      OP_NAND:   res_beh = ~(vec_a & vec_b);
      default:   res_beh = ~(vec_a | vec_b);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = RUN;
      RUN:     if (vec_cnt == VEC_LAST) next_state = DRAIN;
      DRAIN:   next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Compares are pipelined by one cycle. The flag registered with res_s is
  // retired into mismatch_cnt on the following edge, so the last vector's
  // compare lands during DRAIN. done is registered out of DONE so that it
  // rises on the same edge where pass takes its final value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_cnt      <= '0;
      op_q         <= '0;
      res_s        <= '0;
      cmp_flag     <= 1'b0;
      cmp_valid    <= 1'b0;
      mismatch_cnt <= '0;
      pass         <= 1'b0;
      done         <= 1'b0;
    end else begin
      done      <= (state == DONE);
      cmp_valid <= 1'b0;
      if (cmp_valid && cmp_flag && (mismatch_cnt != '1))
        mismatch_cnt <= mismatch_cnt + CNT_ONE;
      case (state)
        IDLE: begin
          if (start) begin
            op_q         <= op;
            vec_cnt      <= '0;
            mismatch_cnt <= '0;
            pass         <= 1'b0;
          end
        end
        RUN: begin
          vec_cnt   <= vec_cnt + VEC_ONE;
          res_s     <= res_struct;
          cmp_flag  <= (res_struct != res_beh);
          cmp_valid <= 1'b1;
        end
        DONE:    pass <= (mismatch_cnt == '0);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_sweep.sv
// tb_truth_sweep
// Directed bench for truth_sweep. It instantiates a W=2 copy for the main
// sweeps and a W=1 copy for the smallest sweep. Define
// TRUTH_SWEEP_FAULT_INJ_EN to also exercise the fault_inj port.
module tb_truth_sweep;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [1:0] op;
  logic       busy;
  logic       done;
  logic [1:0] vec_a;
  logic [1:0] vec_b;
  logic [1:0] res_s;
  logic [4:0] mismatch_cnt;
  logic       pass;

  logic       start1;
  logic [1:0] op1;
  logic       busy1;
  logic       done1;
  logic [0:0] vec_a1;
  logic [0:0] vec_b1;
  logic [0:0] res_s1;
  logic [2:0] mismatch_cnt1;
  logic       pass1;

`ifdef TRUTH_SWEEP_FAULT_INJ_EN
  logic       fault_inj;
`endif
  logic       fault_on;

  int vec_count;
  int miscompares;

  truth_sweep #(.W(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .op           (op),
`ifdef TRUTH_SWEEP_FAULT_INJ_EN
    .fault_inj    (fault_inj),
`endif
    .busy         (busy),
    .done         (done),
    .vec_a        (vec_a),
    .vec_b        (vec_b),
    .res_s        (res_s),
    .mismatch_cnt (mismatch_cnt),
    .pass         (pass)
  );

  truth_sweep #(.W(1)) dut1 (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start1),
    .op           (op1),
`ifdef TRUTH_SWEEP_FAULT_INJ_EN
    .fault_inj    (1'b0),
`endif
    .busy         (busy1),
    .done         (done1),
    .vec_a        (vec_a1),
    .vec_b        (vec_b1),
    .res_s        (res_s1),
    .mismatch_cnt (mismatch_cnt1),
    .pass         (pass1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vec_count++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] model(input logic [1:0] o, input logic [1:0] a,
                                       input logic [1:0] b);
    case (o)
      2'd0:    return ~a & b;
      2'd1:    return a & ~b;
      2'd2:    return ~(a | b);
      default: return ~(a & b);
    endcase
  endfunction

  // Starts a W=2 sweep and follows it cycle by cycle. Sample n is taken just
  // after the n-th edge past the start edge. At cycle disturb_at, start is
  // pulsed again with the inverted op so that the sweep's immunity is checked.
  task automatic applyStimulus(input logic [1:0] op_val, input int disturb_at,
                               output int done_at, output int busy_cnt);
    logic [1:0] exp_r;
    logic [1:0] va;
    logic [1:0] vb;
    op = op_val;
    start = 1'b1;
    tick();
    start = 1'b0;
    busy_cnt = busy ? 1 : 0;
    done_at = -1;
    checkOutput("vec_start", 32'({vec_a, vec_b}), 32'd0);
    for (int n = 1; n <= 40; n++) begin
      if (n == disturb_at) begin
        start = 1'b1;
        op = ~op_val;
      end else if (n == disturb_at + 1) begin
        start = 1'b0;
      end
      tick();
      if (busy) busy_cnt++;
      if (n <= 16) begin
        va = 2'((n - 1) / 4);
        vb = 2'((n - 1) % 4);
        exp_r = model(op_val, va, vb) ^ {1'b0, fault_on};
        checkOutput($sformatf("res_s_v%0d", n - 1), 32'(res_s), 32'(exp_r));
        checkOutput($sformatf("vec_c%0d", n), 32'({vec_a, vec_b}), 32'(n % 16));
      end
      if (done) begin
        done_at = n;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic checkSweepEnd(input string tag, input int done_at,
                               input int busy_cnt, input int exp_mis,
                               input logic exp_pass);
    checkOutput({tag, "_done_at"}, 32'(done_at), 32'd18);
    checkOutput({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd17);
    checkOutput({tag, "_mismatch"}, 32'(mismatch_cnt), 32'(exp_mis));
    checkOutput({tag, "_pass"}, 32'(pass), 32'(exp_pass));
    tick();
    checkOutput({tag, "_done_pulse"}, 32'(done), 32'd0);
    checkOutput({tag, "_hold_mis"}, 32'(mismatch_cnt), 32'(exp_mis));
    checkOutput({tag, "_hold_pass"}, 32'(pass), 32'(exp_pass));
    checkOutput({tag, "_hold_vec"}, 32'({vec_a, vec_b}), 32'd0);
  endtask

  initial begin
    int done_at;
    int busy_cnt;
    int w1_done;
    vec_count = 0;
    miscompares = 0;
    fault_on = 1'b0;
`ifdef TRUTH_SWEEP_FAULT_INJ_EN
    fault_inj = 1'b0;
`endif
    rst_n = 1'b0;
    start = 1'b0;
    op = 2'd0;
    start1 = 1'b0;
    op1 = 2'd0;
    #3;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_vec", 32'({vec_a, vec_b}), 32'd0);
    checkOutput("rst_res_s", 32'(res_s), 32'd0);
    checkOutput("rst_mismatch", 32'(mismatch_cnt), 32'd0);
    checkOutput("rst_pass", 32'(pass), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // One full sweep for each function select.
    for (int o = 0; o < 4; o++) begin
      applyStimulus(2'(o), -10, done_at, busy_cnt);
      checkSweepEnd($sformatf("op%0d", o), done_at, busy_cnt, 0, 1'b1);
    end

    // NOR corner vectors, checked by hand: 0,0 -> 11 and 3,0 -> 00.
    op = 2'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    checkOutput("nor_a0b0", 32'(res_s), 32'd3);
    for (int n = 2; n <= 13; n++) tick();
    checkOutput("nor_a3b0", 32'(res_s), 32'd0);
    for (int n = 14; n <= 20; n++) tick();
    checkOutput("nor_idle_pass", 32'(pass), 32'd1);

    // Start re-pulsed and op flipped in the middle of a sweep.
    applyStimulus(2'd1, 5, done_at, busy_cnt);
    checkSweepEnd("restart_ignored", done_at, busy_cnt, 0, 1'b1);

`ifdef TRUTH_SWEEP_FAULT_INJ_EN
    fault_inj = 1'b1;
    fault_on = 1'b1;
    applyStimulus(2'd0, -10, done_at, busy_cnt);
    fault_inj = 1'b0;
    fault_on = 1'b0;
    checkSweepEnd("fault", done_at, busy_cnt, 16, 1'b0);
`endif

    // Reset asserted at cycle 8 of a sweep.
    op = 2'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 1; n <= 8; n++) tick();
    checkOutput("pre_abort_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_vec", 32'({vec_a, vec_b}), 32'd0);
    checkOutput("abort_res_s", 32'(res_s), 32'd0);
    checkOutput("abort_mismatch", 32'(mismatch_cnt), 32'd0);
    checkOutput("abort_pass", 32'(pass), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int n = 0; n < 12; n++) begin
      tick();
      checkOutput("abort_no_done", 32'({busy, done}), 32'd0);
    end
    applyStimulus(2'd3, -10, done_at, busy_cnt);
    checkSweepEnd("after_abort", done_at, busy_cnt, 0, 1'b1);

    // Smallest configuration: W=1, NAND, four vectors.
    op1 = 2'd3;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    w1_done = -1;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (done1) begin
        w1_done = n;
        break;
      end
    end
    checkOutput("w1_done_at", 32'(w1_done), 32'd6);
    checkOutput("w1_mismatch", 32'(mismatch_cnt1), 32'd0);
    checkOutput("w1_pass", 32'(pass1), 32'd1);
    checkOutput("w1_res_last", 32'(res_s1), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
